// File: rtl/hpu_pkg.sv
// Shared HPU stream constants and the output-buffer release-state encoding.
package hpu_pkg;

    localparam int unsigned AXIS_DATA_W = 64;
    localparam int unsigned AXIS_STRB_W = AXIS_DATA_W / 8;

    // HOLD: at a packet boundary, release gated by store_fwd; CUT: draining a packet to TLAST
    typedef enum logic {
        HOLD = 1'b0,
        CUT  = 1'b1
    } rel_state_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port RAM: one write port, one registered read port with write-through
// so a word written to the address being read is visible on the next cycle.
module fifo_mem_2p #(
    parameter int unsigned WIDTH  = 65,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axis_dst_fifo.sv
// First-word-fall-through AXI-Stream output buffer between the HPU and the DMA S2MM
// channel, with cut-through or store-and-forward packet release and status counters.
module axis_dst_fifo
    import hpu_pkg::*;
#(
    parameter int unsigned DATA_W     = AXIS_DATA_W,
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  AXIS_ACLK,
    input  logic                  AXIS_ARESETN,
    input  logic                  clr,
    input  logic                  store_fwd,
    input  logic                  S_AXIS_TVALID,
    input  logic [DATA_W-1:0]     S_AXIS_TDATA,
    input  logic                  S_AXIS_TLAST,
    output logic                  S_AXIS_TREADY,
    output logic                  M_AXIS_TVALID,
    output logic [DATA_W-1:0]     M_AXIS_TDATA,
    output logic [DATA_W/8-1:0]   M_AXIS_TSTRB,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DEPTH_LOG2:0]   pkt_avail,
    output logic [CNT_W-1:0]      pkt_sent,
    output logic [CNT_W-1:0]      words_sent,
    output logic                  oversize
);
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned ENT_W = DATA_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(2 ** DEPTH_LOG2);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic [PTR_W-1:0] pkt_avail_q, pkt_avail_d;
    logic [CNT_W-1:0] pkt_sent_q, pkt_sent_d;
    logic [CNT_W-1:0] words_sent_q, words_sent_d;
    logic             oversize_q, oversize_d;
    logic             tready_q, tready_d;
    rel_state_t       state_q, state_d;

    logic [ENT_W-1:0] head;
    logic             empty, full, head_last, fallback;
    logic             push, pop, push_last, pop_last;

    assign empty     = (level_q == '0);
    assign full      = (level_q == DEPTH_L);
    assign head_last = head[DATA_W];

    // A full buffer with no complete packet would deadlock store-and-forward; stream it instead
    assign fallback = store_fwd && full && (pkt_avail_q == '0) && (state_q == HOLD);

    assign S_AXIS_TREADY = tready_q && !clr;
    assign M_AXIS_TVALID = !clr && !empty &&
                           (!store_fwd || (pkt_avail_q != '0) || (state_q == CUT) || fallback);

    assign push      = S_AXIS_TVALID && S_AXIS_TREADY;
    assign pop       = M_AXIS_TVALID && M_AXIS_TREADY;
    assign push_last = push && S_AXIS_TLAST;
    assign pop_last  = pop && head_last;

    assign M_AXIS_TDATA = head[DATA_W-1:0];
    assign M_AXIS_TLAST = head_last;
    assign M_AXIS_TSTRB = '1;
    assign level        = level_q;
    assign pkt_avail    = pkt_avail_q;
    assign pkt_sent     = pkt_sent_q;
    assign words_sent   = words_sent_q;
    assign oversize     = oversize_q;

    // Read address tracks the next head so the registered read keeps the head presented
    fifo_mem_2p #(
        .WIDTH  (ENT_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk   (AXIS_ACLK),
        .rst_n (AXIS_ARESETN),
        .we    (push),
        .waddr (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .raddr (rd_ptr_d[DEPTH_LOG2-1:0]),
        .rdata (head)
    );

    // Next-state: pointers, counters and the release state
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        pkt_avail_d  = pkt_avail_q;
        pkt_sent_d   = pkt_sent_q;
        words_sent_d = words_sent_q;
        oversize_d   = oversize_q;
        state_d      = state_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            words_sent_d = words_sent_q + CNT_W'(1);
        end
        if (pop_last) begin
            pkt_sent_d = pkt_sent_q + CNT_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + PTR_W'(1);
            2'b01:   level_d = level_q - PTR_W'(1);
            default: level_d = level_q;
        endcase

        case ({push_last, pop_last})
            2'b10:   pkt_avail_d = pkt_avail_q + PTR_W'(1);
            2'b01:   pkt_avail_d = pkt_avail_q - PTR_W'(1);
            default: pkt_avail_d = pkt_avail_q;
        endcase

        if (fallback) begin
            oversize_d = 1'b1;
        end

        // Any popped non-final word opens the packet so a store_fwd change never freezes it
        case (state_q)
            HOLD:    if (fallback || (pop && !head_last)) state_d = CUT;
            CUT:     if (pop_last) state_d = HOLD;
            default: state_d = HOLD;
        endcase

        if (clr) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            pkt_avail_d  = '0;
            pkt_sent_d   = '0;
            words_sent_d = '0;
            oversize_d   = 1'b0;
            state_d      = HOLD;
        end

        tready_d = (level_d != DEPTH_L);
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            pkt_avail_q  <= '0;
            pkt_sent_q   <= '0;
            words_sent_q <= '0;
            oversize_q   <= 1'b0;
            tready_q     <= 1'b0;
            state_q      <= HOLD;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            pkt_avail_q  <= pkt_avail_d;
            pkt_sent_q   <= pkt_sent_d;
            words_sent_q <= words_sent_d;
            oversize_q   <= oversize_d;
            tready_q     <= tready_d;
            state_q      <= state_d;
        end
    end

endmodule

// File: tb/tb_axis_dst_fifo.sv
// Scoreboard bench for axis_dst_fifo: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_axis_dst_fifo;

    localparam int DEPTH = 32;

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n, clr, sf;
    logic        s_tvalid, s_tlast, m_tready;
    logic [63:0] s_tdata;
    logic        s_tready, m_tvalid, m_tlast, oversize;
    logic [63:0] m_tdata;
    logic [7:0]  m_tstrb;
    logic [5:0]  level, pkt_avail;
    logic [15:0] pkt_sent, words_sent;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    word_t       q[$];
    int unsigned nlast, exp_words, exp_pkts;
    bit          in_pkt, ovs, alive;
    bit          done;

    always #5 clk = ~clk;

    axis_dst_fifo dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESETN  (rst_n),
        .clr           (clr),
        .store_fwd     (sf),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TSTRB  (m_tstrb),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready),
        .level         (level),
        .pkt_avail     (pkt_avail),
        .pkt_sent      (pkt_sent),
        .words_sent    (words_sent),
        .oversize      (oversize)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] d, input logic l);
        int  n;
        bit  acc;
        n = 0;
        acc = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        do begin
            @(negedge clk);
            acc = s_tvalid && s_tready;
            tick();
            n++;
        end while (!acc && n < 3000);
        if (!acc) fail_now("send_word");
        s_tvalid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        if (q.size() != 0) fail_now(name);
    endtask

    // Monitor: compare DUT against the model, then apply this cycle's handshakes to the model
    always @(negedge clk) begin
        word_t w;
        bit    full_m, fb, e_tv, e_tr, popm, pushm;
        if (!rst_n) begin
            chk("rst_tready", 64'(s_tready), 64'(0));
            chk("rst_tvalid", 64'(m_tvalid), 64'(0));
            chk("rst_level", 64'(level), 64'(0));
            chk("rst_pkt_avail", 64'(pkt_avail), 64'(0));
            chk("rst_pkt_sent", 64'(pkt_sent), 64'(0));
            chk("rst_words_sent", 64'(words_sent), 64'(0));
            chk("rst_oversize", 64'(oversize), 64'(0));
            q.delete();
            nlast = 0; exp_words = 0; exp_pkts = 0;
            in_pkt = 1'b0; ovs = 1'b0; alive = 1'b0;
        end else begin
            full_m = (q.size() == DEPTH);
            fb     = sf && full_m && (nlast == 0) && !in_pkt;
            e_tv   = !clr && (q.size() != 0) && (!sf || nlast != 0 || in_pkt || fb);
            e_tr   = alive && !clr && !full_m;
            chk("tvalid", 64'(m_tvalid), 64'(e_tv));
            chk("tready", 64'(s_tready), 64'(e_tr));
            chk("level", 64'(level), 64'(q.size()));
            chk("pkt_avail", 64'(pkt_avail), 64'(nlast));
            chk("words_sent", 64'(words_sent), 64'(16'(exp_words)));
            chk("pkt_sent", 64'(pkt_sent), 64'(16'(exp_pkts)));
            chk("oversize", 64'(oversize), 64'(ovs));
            chk("tstrb", 64'(m_tstrb), 64'hff);
            if (e_tv && m_tvalid) begin
                chk("tdata", m_tdata, q[0].data);
                chk("tlast", 64'(m_tlast), 64'(q[0].last));
            end
            if (clr) begin
                q.delete();
                nlast = 0; exp_words = 0; exp_pkts = 0;
                in_pkt = 1'b0; ovs = 1'b0;
            end else begin
                popm  = e_tv && m_tready;
                pushm = s_tvalid && e_tr;
                if (popm) begin
                    w = q.pop_front();
                    exp_words++;
                    if (w.last) begin
                        exp_pkts++;
                        nlast--;
                        in_pkt = 1'b0;
                    end else begin
                        in_pkt = 1'b1;
                    end
                end else if (fb) begin
                    in_pkt = 1'b1;
                end
                if (fb) ovs = 1'b1;
                if (pushm) begin
                    q.push_back({s_tlast, s_tdata});
                    if (s_tlast) nlast++;
                end
            end
            alive = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base, len;
        rst_n = 1'b0; clr = 1'b0; sf = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
        done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Cut-through, one 8-word packet
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) send_word(64'(i + 1), i == 7);
        wait_empty("t1_drain");
        @(negedge clk);
        chk("t1_words_sent", 64'(words_sent), 64'd8);
        chk("t1_pkt_sent", 64'(pkt_sent), 64'd1);
        tick();

        // Back-pressure: fill to DEPTH, then drain in order
        m_tready = 1'b0;
        fork
            for (int i = 0; i < 40; i++) send_word(64'(i), i == 39);
            begin
                repeat (45) @(negedge clk);
                chk("t2_level_full", 64'(level), 64'd32);
                chk("t2_tready_low", 64'(s_tready), 64'd0);
                tick();
                m_tready = 1'b1;
            end
        join
        wait_empty("t2_drain");

        // Store-and-forward holds an incomplete packet
        sf = 1'b1;
        for (int i = 0; i < 5; i++) send_word(64'(100 + i), 1'b0);
        repeat (3) tick();
        @(negedge clk);
        chk("t3_tvalid_held", 64'(m_tvalid), 64'd0);
        chk("t3_level", 64'(level), 64'd5);
        tick();
        send_word(64'd105, 1'b1);
        wait_empty("t3_drain");

        // Oversize fallback
        for (int i = 0; i < 40; i++) send_word(64'(200 + i), 1'b0);
        send_word(64'd240, 1'b1);
        wait_empty("t4_drain");
        @(negedge clk);
        chk("t4_oversize", 64'(oversize), 64'd1);
        tick();

        // Simultaneous push-TLAST and pop-TLAST at level 10
        sf = 1'b0;
        m_tready = 1'b0;
        for (int i = 0; i < 10; i++) send_word(64'(300 + i), 1'b1);
        tick();
        base = exp_pkts;
        s_tvalid = 1'b1; s_tdata = 64'd310; s_tlast = 1'b1; m_tready = 1'b1;
        @(negedge clk);
        tick();
        s_tvalid = 1'b0; m_tready = 1'b0;
        @(negedge clk);
        chk("t5_level", 64'(level), 64'd10);
        chk("t5_pkt_avail", 64'(pkt_avail), 64'd10);
        chk("t5_pkt_sent", 64'(pkt_sent), 64'(16'(base + 1)));
        tick();
        m_tready = 1'b1;
        wait_empty("t5_drain");

        // Asynchronous reset mid-packet
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) send_word(64'(400 + i), 1'b0);
        s_tvalid = 1'b1; s_tdata = 64'd403; s_tlast = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_level", 64'(level), 64'd0);
        chk("t6_async_tvalid", 64'(m_tvalid), 64'd0);
        chk("t6_async_tready", 64'(s_tready), 64'd0);
        chk("t6_async_oversize", 64'(oversize), 64'd0);
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // clr with a word presented: flushes everything and drops the word
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) send_word(64'(500 + i), i == 3);
        wait_empty("t6_pre_clr");
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) send_word(64'(510 + i), 1'b0);
        clr = 1'b1; s_tvalid = 1'b1; s_tdata = 64'hdead; s_tlast = 1'b1;
        @(negedge clk);
        chk("t6_clr_tready", 64'(s_tready), 64'd0);
        tick();
        clr = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
        @(negedge clk);
        chk("t6_clr_level", 64'(level), 64'd0);
        chk("t6_clr_words_sent", 64'(words_sent), 64'd0);
        chk("t6_clr_pkt_avail", 64'(pkt_avail), 64'd0);
        repeat (3) @(negedge clk);
        chk("t6_clr_not_stored", 64'(m_tvalid), 64'd0);
        tick();

        // Randomized packets, store_fwd chosen per packet, random sink stalls
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    sf = 1'($urandom_range(0, 1));
                    len = ($urandom_range(0, 9) == 0) ? 37 : $urandom_range(1, 10);
                    for (int k = 0; k < int'(len); k++) begin
                        if ($urandom_range(0, 3) == 0) tick();
                        send_word({$urandom, $urandom}, k == int'(len) - 1);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_tready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        m_tready = 1'b1;
        wait_empty("rand_drain");
        @(negedge clk);
        chk("rand_level_end", 64'(level), 64'd0);
        chk("rand_pkt_sent", 64'(pkt_sent), 64'(16'(exp_pkts)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
